// File: rtl/dcache_refill_ctrl.sv
// Miss-handling controller for the two-way data cache: stalls the pipeline on a
// load miss, fetches the word from memory, refills the cache and returns the load.
module dcache_refill_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int WAIT_LIMIT = 255,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic                  cache_hit,
    input  logic [DATA_WIDTH-1:0] cache_data,
    output logic                  stall,
    output logic                  load_valid,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [DATA_WIDTH-1:0] mem_addr,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_resp_data,
    output logic                  refill_we,
    output logic [DATA_WIDTH-1:0] refill_addr,
    output logic [DATA_WIDTH-1:0] refill_data,
    output logic                  retry_pulse,
    output logic [CNT_WIDTH-1:0]  miss_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_FILL = 2'd3
    } state_t;

    localparam logic [7:0]            WAIT_LAST  = 8'(WAIT_LIMIT - 1);
    localparam logic [DATA_WIDTH-1:0] WORD_MASK  = {{(DATA_WIDTH-2){1'b1}}, 2'b00};
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE    = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX    = {CNT_WIDTH{1'b1}};

    state_t                  state_r;
    logic [DATA_WIDTH-1:0]   addr_r;
    logic [DATA_WIDTH-1:0]   data_r;
    logic [7:0]              wait_cnt_r;
    logic [CNT_WIDTH-1:0]    miss_count_r;

    logic                    miss_s;
    logic                    timeout_s;

    assign miss_s    = (state_r == ST_IDLE) && req_valid && !cache_hit;
    assign timeout_s = (state_r == ST_WAIT) && !mem_resp_valid && (wait_cnt_r == WAIT_LAST);
    assign miss_count = miss_count_r;

    // Controller state, captured miss address/data, wait timer and miss counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            addr_r       <= '0;
            data_r       <= '0;
            wait_cnt_r   <= 8'd0;
            miss_count_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (miss_s) begin
                        addr_r  <= req_addr & WORD_MASK;
                        state_r <= ST_REQ;
                        if (miss_count_r != CNT_MAX) begin
                            miss_count_r <= miss_count_r + CNT_ONE;
                        end else begin
                            miss_count_r <= miss_count_r;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready) begin
                        wait_cnt_r <= 8'd0;
                        state_r    <= ST_WAIT;
                    end else begin
                        state_r    <= ST_REQ;
                    end
                end
                ST_WAIT: begin
                    // A response in the expiring cycle takes priority over the retry.
                    if (mem_resp_valid) begin
                        data_r  <= mem_resp_data;
                        state_r <= ST_FILL;
                    end else if (timeout_s) begin
                        wait_cnt_r <= wait_cnt_r + 8'd1;
                        state_r    <= ST_REQ;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 8'd1;
                        state_r    <= ST_WAIT;
                    end
                end
                ST_FILL: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Output decode; hit return and miss stall must respond in the request cycle.
    always_comb begin
        stall         = 1'b0;
        load_valid    = 1'b0;
        load_data     = '0;
        mem_req_valid = 1'b0;
        mem_addr      = addr_r;
        refill_we     = 1'b0;
        refill_addr   = '0;
        refill_data   = '0;
        retry_pulse   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_valid && cache_hit) begin
                    load_valid = 1'b1;
                    load_data  = cache_data;
                end else if (req_valid) begin
                    stall      = 1'b1;
                end else begin
                    stall      = 1'b0;
                end
            end
            ST_REQ: begin
                stall         = 1'b1;
                mem_req_valid = 1'b1;
            end
            ST_WAIT: begin
                stall       = 1'b1;
                retry_pulse = timeout_s;
            end
            ST_FILL: begin
                refill_we   = 1'b1;
                refill_addr = addr_r;
                refill_data = data_r;
                load_valid  = 1'b1;
                load_data   = data_r;
            end
            default: begin
                stall = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_dcache_refill_ctrl.sv
// Randomized scoreboard bench for dcache_refill_ctrl: the driver plays pipeline and
// memory, queues the expected returned loads and refills; a monitor checks them.
module tb_dcache_refill_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        cache_hit;
    logic [31:0] cache_data;
    logic        stall;
    logic        load_valid;
    logic [31:0] load_data;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        refill_we;
    logic [31:0] refill_addr;
    logic [31:0] refill_data;
    logic        retry_pulse;
    logic [1:0]  miss_count;

    int checks = 0;
    int errors = 0;
    int exp_miss = 0;
    int exp_retries = 0;
    int seen_retries = 0;
    logic [31:0] exp_load_q[$];
    logic [63:0] exp_fill_q[$];

    always #5 clk = ~clk;

    dcache_refill_ctrl #(
        .DATA_WIDTH (32),
        .WAIT_LIMIT (4),
        .CNT_WIDTH  (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .cache_hit      (cache_hit),
        .cache_data     (cache_data),
        .stall          (stall),
        .load_valid     (load_valid),
        .load_data      (load_data),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_addr       (mem_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .refill_we      (refill_we),
        .refill_addr    (refill_addr),
        .refill_data    (refill_data),
        .retry_pulse    (retry_pulse),
        .miss_count     (miss_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_count();
        return (exp_miss > 3) ? 32'd3 : 32'(exp_miss);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic noise();
        req_valid  = 1'($urandom);
        cache_hit  = 1'($urandom);
        cache_data = $urandom;
        req_addr   = $urandom;
    endtask

    task automatic do_hit(input logic [31:0] data);
        req_valid      = 1'b1;
        cache_hit      = 1'b1;
        cache_data     = data;
        req_addr       = $urandom;
        mem_req_ready  = 1'($urandom);
        mem_resp_valid = 1'($urandom);
        mem_resp_data  = $urandom;
        exp_load_q.push_back(data);
        #1;
        chk("hit_stall", 32'(stall), 32'd0);
        chk("hit_mem_req", 32'(mem_req_valid), 32'd0);
        tick();
        req_valid = 1'b0;
        chk("hit_miss_count", 32'(miss_count), model_count());
    endtask

    task automatic do_miss(input logic [31:0] addr, input logic [31:0] word,
                           input int r0, input int d0);
        logic [31:0] aligned;
        int attempt;
        int r;
        int d;
        bit done;
        aligned        = {addr[31:2], 2'b00};
        req_valid      = 1'b1;
        cache_hit      = 1'b0;
        req_addr       = addr;
        cache_data     = $urandom;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        exp_miss++;
        exp_load_q.push_back(word);
        exp_fill_q.push_back({aligned, word});
        #1;
        chk("miss_stall", 32'(stall), 32'd1);
        chk("miss_no_load", 32'(load_valid), 32'd0);
        tick();
        attempt = 0;
        done    = 1'b0;
        while (!done) begin
            r = (attempt == 0) ? r0 : int'($urandom_range(0, 2));
            if (attempt == 0) d = d0;
            else if (attempt >= 2) d = int'($urandom_range(0, 3));
            else d = int'($urandom_range(0, 5));
            for (int i = 0; i <= r; i++) begin
                noise();
                mem_req_ready  = (i == r);
                mem_resp_valid = 1'($urandom);
                mem_resp_data  = $urandom;
                #1;
                chk("req_valid", 32'(mem_req_valid), 32'd1);
                chk("req_addr", mem_addr, aligned);
                chk("req_stall", 32'(stall), 32'd1);
                chk("req_retry", 32'(retry_pulse), 32'd0);
                tick();
            end
            for (int k = 0; k < 4; k++) begin
                noise();
                mem_req_ready  = 1'($urandom);
                mem_resp_valid = (k == d);
                mem_resp_data  = (k == d) ? word : $urandom;
                #1;
                chk("wait_mem_req", 32'(mem_req_valid), 32'd0);
                chk("wait_stall", 32'(stall), 32'd1);
                chk("wait_retry", 32'(retry_pulse), 32'((k == 3) && (d != 3)));
                tick();
                if (k == d) begin
                    done = 1'b1;
                    break;
                end
                if (k == 3) exp_retries++;
            end
            attempt++;
        end
        noise();
        mem_resp_valid = 1'b0;
        mem_req_ready  = 1'b0;
        #1;
        chk("fill_stall", 32'(stall), 32'd0);
        chk("fill_load_valid", 32'(load_valid), 32'd1);
        chk("fill_we", 32'(refill_we), 32'd1);
        tick();
        req_valid = 1'b0;
        chk("miss_count", 32'(miss_count), model_count());
    endtask

    // Scoreboard monitor: every returned load and every refill must match the queue head.
    always @(negedge clk) begin
        if (rst_n) begin
            if (load_valid) begin
                if (exp_load_q.size() == 0) chk("load_unexpected", 32'(load_valid), 32'd0);
                else chk("load_data", load_data, exp_load_q.pop_front());
            end
            if (refill_we) begin
                if (exp_fill_q.size() == 0) begin
                    chk("refill_unexpected", 32'(refill_we), 32'd0);
                end else begin
                    logic [63:0] e;
                    e = exp_fill_q.pop_front();
                    chk("refill_addr", refill_addr, e[63:32]);
                    chk("refill_data", refill_data, e[31:0]);
                end
            end
            if (retry_pulse) seen_retries++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        req_valid      = 1'b0;
        req_addr       = 32'd0;
        cache_hit      = 1'b0;
        cache_data     = 32'd0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = 32'd0;
        repeat (3) tick();
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_load_valid", 32'(load_valid), 32'd0);
        chk("rst_mem_req", 32'(mem_req_valid), 32'd0);
        chk("rst_refill_we", 32'(refill_we), 32'd0);
        chk("rst_retry", 32'(retry_pulse), 32'd0);
        chk("rst_miss_count", 32'(miss_count), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        rst_n = 1'b1;
        tick();

        do_hit(32'hDEAD_BEEF);
        do_miss(32'h0000_1237, 32'hCAFE_F00D, 0, 0);
        do_miss(32'h0000_2002, 32'h1234_5678, 4, 1);
        do_miss(32'h0000_3001, 32'h8765_4321, 0, 9);
        do_miss(32'h0000_4003, 32'h0BAD_CAFE, 1, 3);

        for (int t = 0; t < 60; t++) begin
            int gap;
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                req_valid      = 1'b0;
                mem_resp_valid = 1'($urandom);
                mem_resp_data  = $urandom;
                tick();
            end
            if ($urandom_range(0, 1) == 0) do_hit($urandom);
            else do_miss($urandom, $urandom, int'($urandom_range(0, 3)),
                         int'($urandom_range(0, 5)));
        end

        // Abort a miss in WAIT with reset; the late response must be dropped.
        req_valid      = 1'b1;
        cache_hit      = 1'b0;
        req_addr       = 32'h0000_5555;
        mem_resp_valid = 1'b0;
        tick();
        req_valid     = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("abort_stall", 32'(stall), 32'd0);
        chk("abort_count", 32'(miss_count), 32'd0);
        tick();
        rst_n          = 1'b1;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'hFFFF_0000;
        #1;
        chk("abort_refill_we", 32'(refill_we), 32'd0);
        chk("abort_stall_post", 32'(stall), 32'd0);
        tick();
        mem_resp_valid = 1'b0;
        chk("abort_refill_we_2", 32'(refill_we), 32'd0);
        chk("abort_mem_req", 32'(mem_req_valid), 32'd0);
        chk("abort_load_valid", 32'(load_valid), 32'd0);
        exp_miss = 0;
        do_miss(32'h0000_6006, 32'h600D_600D, 0, 0);

        tick();
        chk("retry_total", 32'(seen_retries), 32'(exp_retries));
        chk("load_q_drained", 32'(exp_load_q.size()), 32'd0);
        chk("fill_q_drained", 32'(exp_fill_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
